// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives all four {a,b} vectors into a 2-input gate, holds each for SETTLE cycles,
//    samples y at the end of each hold, and reports mismatches against the EXPECT truth table.
//    Ports: clk, rst_n (async active-low), start (sweep request), a/b (gate inputs), y (gate output),
//    busy (sweep running), done (completion pulse), pass (last sweep clean), err_cnt (mismatch count),
//    fail_mask (per-vector mismatch flags, bit {a,b}).
module gate_sweep_checker #(
   parameter int unsigned SETTLE = 2,
   parameter logic [3:0]  EXPECT = 4'b1110
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [3:0] fail_mask
);
   typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;
   state_t     state;
   logic [3:0] hold;
   logic [1:0] vec;
   logic       mis;
   logic       last;
   assign vec  = {a, b};
   assign mis  = y != EXPECT[vec];
   assign last = hold == 4'(SETTLE - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold      <= '0;
         {a, b}    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         fail_mask <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state     <= DRIVE;
               busy      <= 1'b1;
               {a, b}    <= '0;
               hold      <= '0;
               err_cnt   <= '0;
               fail_mask <= '0;
               pass      <= 1'b0;
            end
            DRIVE: if (!last) hold <= hold + 4'd1;
            else begin
               hold <= '0;
               if (mis) begin
                  fail_mask[vec] <= 1'b1;
                  err_cnt        <= err_cnt + 3'd1;
               end
               // the vector-11 sample is folded into pass here, since err_cnt has not updated yet
               if (vec == 2'b11) begin
                  state  <= FINISH;
                  {a, b} <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  pass   <= err_cnt == 3'd0 && !mis;
               end else {a, b} <= vec + 2'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: randomized sweeps against a cycle-indexed behavioural model, plus literal checks.
module tb_gate_sweep_checker;
   localparam int S = 2;
   localparam logic [3:0] EX = 4'b1110;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0;
   logic a, b, y, busy, done, pass;
   logic [2:0] err_cnt;
   logic [3:0] fail_mask;
   logic a1, b1, y1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [3:0] mask1;
   logic [3:0] gate_tbl = 4'b1110;
   int tests = 0, failed = 0;
   always #5 clk = ~clk;
   assign y  = gate_tbl[{a, b}];
   assign y1 = a1 | b1;
   gate_sweep_checker #(.SETTLE(S), .EXPECT(EX)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .y(y), .busy(busy),
      .done(done), .pass(pass), .err_cnt(err_cnt), .fail_mask(fail_mask));
   gate_sweep_checker #(.SETTLE(1), .EXPECT(EX)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1), .busy(busy1),
      .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1));
   // model: k = edges since the accepting edge; vector v is sampled at edge (v+1)*S, sweep ends at 4*S
   bit active = 0;
   int k = 0;
   logic [3:0] bad = '0, h_mask = '0;
   int h_err = 0;
   bit h_pass = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active = 0; k = 0; h_err = 0; h_mask = '0; h_pass = 0;
      end else if (active) begin
         k++;
         if (k == 4 * S) begin
            h_mask = bad; h_err = $countones(bad); h_pass = bad == 4'd0;
         end
         if (k > 4 * S) active = 0;
      end else if (start) begin
         active = 1; k = 0; bad = gate_tbl ^ EX; h_err = 0; h_mask = '0; h_pass = 0;
      end
   end
   always @(negedge clk) begin
      if (rst_n) begin
         logic [11:0] exp_v;
         logic [3:0] pm;
         int pe;
         bit run;
         run = active && k < 4 * S;
         pm = '0; pe = 0;
         for (int v = 0; v < 4; v++)
            if ((v + 1) * S <= k && bad[v]) begin pm[v] = 1'b1; pe++; end
         exp_v = run ? {2'(k / S), 1'b1, 1'b0, 1'b0, 3'(pe), pm}
                     : {2'b00, 1'b0, 1'(active && k == 4 * S), h_pass, 3'(h_err), h_mask};
         tests++;
         if ({a, b, busy, done, pass, err_cnt, fail_mask} !== exp_v) begin
            failed++;
            $display("FAIL model k=%0d got ab/busy/done/pass/err/mask=%b want %b", k,
                     {a, b, busy, done, pass, err_cnt, fail_mask}, exp_v);
         end
      end
   end
   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         failed++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask
   task automatic run_sweep(input logic [3:0] tbl, output int lat);
      @(negedge clk);
      gate_tbl = tbl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask
   initial begin
      int lat, n_done;
      repeat (2) @(negedge clk);
      #1 chk("reset_vals", int'({a, b, busy, done, pass, err_cnt, fail_mask}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(4'b1110, lat);
      chk("or_latency", lat, 8);
      chk("or_pass", int'(pass), 1);
      chk("or_err", int'(err_cnt), 0);
      chk("or_mask", int'(fail_mask), 0);
      run_sweep(4'b0000, lat);
      chk("zero_pass", int'(pass), 0);
      chk("zero_err", int'(err_cnt), 3);
      chk("zero_mask", int'(fail_mask), 4'b1110);
      @(negedge clk);
      chk("idle_hold_err", int'(err_cnt), 3);
      run_sweep(4'b1000, lat);
      chk("and_err", int'(err_cnt), 2);
      chk("and_mask", int'(fail_mask), 4'b0110);
      for (int i = 0; i < 8; i++) begin
         run_sweep(4'($urandom_range(0, 15)), lat);
         chk("rand_latency", lat, 8);
      end
      // held start: FINISH ignores start and one IDLE cycle follows, so a sweep repeats every 10 edges
      @(negedge clk);
      gate_tbl = 4'b1110;
      start = 1'b1;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            chk("held_pass", int'(pass), 1);
         end
      end
      start = 1'b0;
      chk("held_dones", n_done, 4);
      repeat (12) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0;
      chk("pre_rst_vec", int'({a, b}), 2);
      #2 rst_n = 1'b0;
      #1 chk("midrst_vals", int'({a, b, busy, done, pass, err_cnt, fail_mask}), 0);
      @(negedge clk);
      chk("midrst_done", int'(done), 0);
      rst_n = 1'b1;
      run_sweep(4'b1110, lat);
      chk("post_rst_latency", lat, 8);
      chk("post_rst_pass", int'(pass), 1);
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk("s1_vec", int'({a1, b1}), j);
         chk("s1_busy", int'(busy1), 1);
         @(negedge clk);
      end
      chk("s1_done", int'(done1), 1);
      chk("s1_pass", int'(pass1), 1);
      chk("s1_err", int'({err1, mask1}), 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
